spectrum_accumulator: RTL and testbench
=======================================

Name: spectrum_accumulator

Overview:
Receiving end of the batch stream produced by the sample time buffer after the FFT: consumes RUNS packets of BATCH_SIZE complex bins framed by valid/sop/eop. Computes per-bin power re²+im² and accumulates it across the RUNS packets into an on-chip RAM. Exposes the summed spectrum through a synchronous read port for the downstream detector/host interface.

Parameters:
DATA_WIDTH, 16, bits per signed real/imag component from the FFT
BATCH_SIZE, 2048, bins per packet (≥4)
RUNS, 3, packets accumulated per arm
ACC_WIDTH, 2*DATA_WIDTH+1+$clog2(RUNS), accumulator entry width (derived, do not override)

Ports:
sink_clk  in  1  single clock for the whole block
reset  in  1  asynchronous, active-high reset
arm  in  1  pulse: start a new accumulation
busy  out  1  high while waiting for or accumulating packets
done  out  1  high once accumulation has ended, successfully or with error
error  out  1  high: framing error aborted the accumulation
result_valid  out  1  high: RAM holds a complete RUNS-packet sum
sink_valid  in  1  input beat valid
sink_sop  in  1  first bin of packet
sink_eop  in  1  last bin of packet
sink_real  in  DATA_WIDTH  signed real part
sink_imag  in  DATA_WIDTH  signed imag part
rd_addr  in  $clog2(BATCH_SIZE)  bin to read
rd_data  out  ACC_WIDTH  accumulated power of rd_addr

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, error=0, result_valid=0, rd_data=0; counters cleared; RAM contents not cleared.
- No backpressure: every beat with sink_valid=1 is consumed in its cycle.
- States: IDLE, WAIT_SOP, ACCUM, FLUSH, FINISHED.
- IDLE: arm -> WAIT_SOP, run=0, bin=0; done/error/result_valid cleared. Beats ignored.
- WAIT_SOP: valid beat without sop is discarded silently; valid beat with sop is bin 0 -> ACCUM.
- ACCUM: each valid beat is bin index `bin`; bin increments per beat.
  - sop at bin≠0 -> framing error.
  - eop at bin≠BATCH_SIZE-1, or bin==BATCH_SIZE-1 without eop -> framing error.
  - Correct eop: if run==RUNS-1 -> FLUSH; else run++, bin=0, -> WAIT_SOP.
- Framing error: pending pipeline writes are discarded; -> FINISHED with error=1, result_valid=0.
- FLUSH: drain pipeline; -> FINISHED with error=0, result_valid=1.
- FINISHED: done=1, busy=0. arm -> WAIT_SOP (restart, clears flags). Also arm in IDLE works; arm in WAIT_SOP/ACCUM/FLUSH ignored.
- busy=1 exactly in WAIT_SOP, ACCUM, FLUSH.
- Pipeline: S1 registers re, im, bin, first-run flag. S2 computes power = re²+im² (unsigned, 2*DATA_WIDTH+1 bits) and reads RAM[bin]. S3 writes RAM[bin] = power (run 0) or RAM[bin]+power (run>0), zero-extended to ACC_WIDTH, no saturation.
- Successive beats hit distinct addresses (BATCH_SIZE≥4 guarantees it across packet boundaries), so no forwarding is needed.
- Timing: final eop beat accepted in cycle t -> last write at t+3 -> done=1 and result_valid=1 visible from t+4.
- Read port: dual-port RAM second port; rd_data = RAM[rd_addr] registered, 1-cycle latency, always active. Data is defined only while result_valid=1.
- Simultaneous arm and valid beat in IDLE/FINISHED: the beat is ignored; arm takes effect the next cycle.
- reset mid-accumulation: immediate return to IDLE; partial RAM content is don't-care.

Decomposition:
- Shared package (with time_buffer constants): ACC_WIDTH derivation function, state enum, default BATCH_SIZE/RUNS.
- One sub-module: spectrum_acc_ram, simple dual-port RAM (write port + accumulate-read port, independent read port), BATCH_SIZE × ACC_WIDTH, 1-cycle read.

Test Plan (BATCH_SIZE=8, RUNS=3, DATA_WIDTH=8):
- arm, 3 clean packets with re=bin, im=1 -> done=1, error=0, result_valid=1 at eop3+4 cycles; rd_data[k]=3*(k²+1), e.g. bin 7 -> 150.
- re=-128, im=-128 all bins, 3 runs -> rd_data=3*32768=98304 (no overflow, ACC_WIDTH=19).
- Non-sop beats before each sop plus gaps in sink_valid inside packets -> ignored/tolerated; sums identical to scenario 1.
- Early eop at bin 5 of run 1 -> done=1, error=1, result_valid=0, busy=0; re-arm plus 3 clean packets -> error=0, correct sums.
- sop asserted at bin 3 of run 0 -> error=1; arm during ACCUM -> no effect on counters.
- Assert reset during run 2 -> all outputs 0 in the same cycle, asynchronously; release, arm, clean run -> correct result.

Source files
------------

// File: rtl/spectrum_accumulator_pkg.sv
// spectrum_accumulator_pkg: shared constants, FSM states and accumulator width derivation
// Shared with the sample time buffer so both ends agree on packet geometry.
package spectrum_accumulator_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BATCH_SIZE = 2048;
  localparam int DEF_RUNS       = 3;
  typedef enum logic [2:0] {IDLE, WAIT_SOP, ACCUM, FLUSH, FINISHED} acc_state_e;
  // Power needs 2*dw+1 bits; summing `runs` of them needs clog2(runs) more.
  function automatic int acc_width(input int dw, input int runs);
    return 2 * dw + 1 + $clog2(runs);
  endfunction
endpackage

// File: rtl/spectrum_acc_ram.sv
// spectrum_acc_ram: dual-port RAM with an accumulate-read port and an independent registered read port
// Ports: clk/rst; we_i/waddr_i/wdata_i write port; acc_addr_i/acc_data_o read for read-modify-write;
// rd_addr_i/rd_data_o host read port (1-cycle latency, cleared by rst).
module spectrum_acc_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 19,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    acc_addr_i,
  output logic [WIDTH-1:0] acc_data_o,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    acc_data_o <= mem[acc_addr_i];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data_o <= '0;
    else rd_data_o <= mem[rd_addr_i];
endmodule

// File: rtl/spectrum_accumulator.sv
// spectrum_accumulator: accumulates per-bin power re^2+im^2 over RUNS framed packets into RAM
// Ports: sink_clk/reset (async, active-high); arm starts an accumulation; busy/done/error/result_valid
// status; sink_valid/sop/eop/real/imag input beats (no backpressure); rd_addr/rd_data registered read.
module spectrum_accumulator
  import spectrum_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BATCH_SIZE = DEF_BATCH_SIZE,
  parameter int RUNS       = DEF_RUNS,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, RUNS),
  localparam int BW = $clog2(BATCH_SIZE),
  localparam int RW = RUNS > 1 ? $clog2(RUNS) : 1,
  localparam int PW = 2 * DATA_WIDTH + 1
) (
  input  logic                         sink_clk,
  input  logic                         reset,
  input  logic                         arm,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         result_valid,
  input  logic                         sink_valid,
  input  logic                         sink_sop,
  input  logic                         sink_eop,
  input  logic signed [DATA_WIDTH-1:0] sink_real,
  input  logic signed [DATA_WIDTH-1:0] sink_imag,
  input  logic [BW-1:0]                rd_addr,
  output logic [ACC_WIDTH-1:0]         rd_data
);
  acc_state_e state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [BW-1:0] bin_q, bin_d, s1_bin_q, s2_bin_q, s3_bin_q;
  logic error_q, error_d, rv_q, rv_d, accept, frame_err, last;
  logic s1_v_q, s2_v_q, s3_v_q, s1_first_q, s2_first_q;
  logic signed [DATA_WIDTH-1:0] s1_re_q, s1_im_q;
  logic signed [2*DATA_WIDTH-1:0] re_sq, im_sq;
  logic [PW-1:0] pwr, s2_pwr_q;
  logic [ACC_WIDTH-1:0] acc_data, s3_data_q;
  assign last         = bin_q == BW'(BATCH_SIZE - 1);
  assign busy         = state_q == WAIT_SOP || state_q == ACCUM || state_q == FLUSH;
  assign done         = state_q == FINISHED;
  assign error        = error_q;
  assign result_valid = rv_q;
  assign re_sq        = s1_re_q * s1_re_q;
  assign im_sq        = s1_im_q * s1_im_q;
  assign pwr          = PW'($unsigned(re_sq)) + PW'($unsigned(im_sq));
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    bin_d     = bin_q;
    error_d   = error_q;
    rv_d      = rv_q;
    accept    = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE, FINISHED: if (arm) begin
        state_d = WAIT_SOP;
        run_d   = '0;
        bin_d   = '0;
        error_d = 1'b0;
        rv_d    = 1'b0;
      end
      WAIT_SOP: if (sink_valid && sink_sop) begin
        frame_err = sink_eop;
        accept    = !sink_eop;
        bin_d     = BW'(1);
        state_d   = sink_eop ? state_q : ACCUM;
      end
      ACCUM: if (sink_valid) begin
        frame_err = sink_sop || (sink_eop != last);
        accept    = !frame_err;
        bin_d     = last ? '0 : bin_q + BW'(1);
        run_d     = last && run_q != RW'(RUNS - 1) ? run_q + RW'(1) : run_q;
        state_d   = !last ? ACCUM : run_q == RW'(RUNS - 1) ? FLUSH : WAIT_SOP;
      end
      FLUSH: if (!s1_v_q && !s2_v_q) begin
        state_d = FINISHED;
        rv_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (frame_err) begin
      state_d = FINISHED;
      run_d   = run_q;
      bin_d   = bin_q;
      error_d = 1'b1;
      rv_d    = 1'b0;
    end
  end
  // A framing error kills every in-flight beat; the stage-3 write already
  // committed this edge is harmless because result_valid stays low.
  always_ff @(posedge sink_clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      run_q      <= '0;
      bin_q      <= '0;
      error_q    <= 1'b0;
      rv_q       <= 1'b0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_bin_q   <= '0;
      s1_first_q <= 1'b0;
      s2_pwr_q   <= '0;
      s2_bin_q   <= '0;
      s2_first_q <= 1'b0;
      s3_bin_q   <= '0;
      s3_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      bin_q      <= bin_d;
      error_q    <= error_d;
      rv_q       <= rv_d;
      s1_v_q     <= accept;
      s2_v_q     <= s1_v_q && !frame_err;
      s3_v_q     <= s2_v_q && !frame_err;
      if (accept) begin
        s1_re_q    <= sink_real;
        s1_im_q    <= sink_imag;
        s1_bin_q   <= bin_q;
        s1_first_q <= run_q == '0;
      end
      s2_pwr_q   <= pwr;
      s2_bin_q   <= s1_bin_q;
      s2_first_q <= s1_first_q;
      s3_bin_q   <= s2_bin_q;
      s3_data_q  <= s2_first_q ? ACC_WIDTH'(s2_pwr_q) : acc_data + ACC_WIDTH'(s2_pwr_q);
    end
  spectrum_acc_ram #(.DEPTH(BATCH_SIZE), .WIDTH(ACC_WIDTH)) u_ram (
    .clk       (sink_clk),
    .rst       (reset),
    .we_i      (s3_v_q),
    .waddr_i   (s3_bin_q),
    .wdata_i   (s3_data_q),
    .acc_addr_i(s1_bin_q),
    .acc_data_o(acc_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );
endmodule

// File: tb/tb_spectrum_accumulator.sv
// tb_spectrum_accumulator: scenario tasks with a per-bin power model and read-back scoreboard
module tb_spectrum_accumulator;
  localparam int DW = 8;
  localparam int BS = 8;
  localparam int RN = 3;
  localparam int AW = 19;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic arm = 1'b0;
  logic busy, done, error, result_valid;
  logic sink_valid = 1'b0;
  logic sink_sop = 1'b0;
  logic sink_eop = 1'b0;
  logic signed [DW-1:0] sink_real = '0;
  logic signed [DW-1:0] sink_imag = '0;
  logic [2:0] rd_addr = '0;
  logic [AW-1:0] rd_data;
  int checks = 0;
  int errors = 0;
  int exp_mem [BS];
  int mrun = 0;
  int unsigned sb [$];
  always #5 clk = ~clk;
  spectrum_accumulator #(.DATA_WIDTH(DW), .BATCH_SIZE(BS), .RUNS(RN)) dut (
    .sink_clk    (clk),
    .reset       (reset),
    .arm         (arm),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .result_valid(result_valid),
    .sink_valid  (sink_valid),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .sink_real   (sink_real),
    .sink_imag   (sink_imag),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );
  task automatic beat(input bit v, input bit s, input bit e, input int re, input int im, input bit a);
    @(negedge clk);
    sink_valid = v;
    sink_sop   = s;
    sink_eop   = e;
    sink_real  = DW'(re);
    sink_imag  = DW'(im);
    arm        = a;
  endtask
  task automatic do_arm();
    @(negedge clk);
    sink_valid = 1'b0;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    mrun = 0;
  endtask
  task automatic send_pkt(input int pat, input bit gaps, input bit junk, input int arm_at);
    int re, im;
    if (junk) repeat (2) beat(1, 0, 0, 5, 5, 0);
    for (int b = 0; b < BS; b++) begin
      if (gaps && (b == 2 || b == 5)) beat(0, 0, 0, 0, 0, 0);
      re = pat == 1 ? -128 : pat == 2 ? int'($urandom_range(255)) - 128 : b;
      im = pat == 1 ? -128 : pat == 2 ? int'($urandom_range(255)) - 128 : 1;
      beat(1, b == 0, b == BS - 1, re, im, b == arm_at);
      exp_mem[b] = (mrun == 0 ? 0 : exp_mem[b]) + re * re + im * im;
    end
    mrun++;
  endtask
  task automatic wait_done(input string name);
    int n;
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    arm = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL %s done_latency got %0d extra edges exp 3", name, n);
    end
  endtask
  task automatic read_check(input string name);
    int unsigned e;
    for (int k = 0; k < BS; k++) begin
      @(negedge clk);
      rd_addr = 3'(k);
      sb.push_back(exp_mem[k]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (rd_data !== AW'(e)) begin
        errors++;
        $display("FAIL %s rd_data[%0d] got %0d exp %0d", name, k, rd_data, e);
      end
    end
  endtask
  task automatic run_clean(input int pat, input bit gaps, input bit junk, input int arm_at, input string name);
    do_arm();
    repeat (RN) send_pkt(pat, gaps, junk, arm_at);
    wait_done(name);
    checks++;
    if ({busy, done, error, result_valid} !== 4'b0101) begin
      errors++;
      $display("FAIL %s flags {busy,done,error,rv} got %b exp 0101", name, {busy, done, error, result_valid});
    end
    read_check(name);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, error, result_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset flags got %b exp 0000", {busy, done, error, result_valid});
    end
    checks++;
    if (rd_data !== '0) begin
      errors++;
      $display("FAIL reset rd_data got %0d exp 0", rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic check_err_flags(input string name);
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    arm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, error, result_valid} !== 4'b0110) begin
      errors++;
      $display("FAIL %s flags {busy,done,error,rv} got %b exp 0110", name, {busy, done, error, result_valid});
    end
  endtask
  task automatic test_early_eop();
    do_arm();
    send_pkt(0, 0, 0, -1);
    for (int b = 0; b <= 5; b++) beat(1, b == 0, b == 5, b, 1, 0);
    check_err_flags("early_eop");
    run_clean(0, 0, 0, -1, "rearm_after_eop");
  endtask
  task automatic test_sop_mid();
    do_arm();
    for (int b = 0; b <= 3; b++) beat(1, b == 0 || b == 3, 0, b, 1, b == 1);
    check_err_flags("sop_mid");
  endtask
  task automatic test_reset_mid();
    do_arm();
    send_pkt(0, 0, 0, -1);
    send_pkt(0, 0, 0, -1);
    for (int b = 0; b <= 3; b++) beat(1, b == 0, 0, b, 1, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, result_valid} !== 4'b0000 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got flags %b rd_data %0d exp 0000/0", {busy, done, error, result_valid}, rd_data);
    end
    sink_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_clean(0, 0, 0, -1, "after_reset_mid");
  endtask
  initial begin
    test_reset();
    run_clean(0, 0, 0, -1, "clean_ramp");
    run_clean(1, 0, 0, -1, "max_neg");
    run_clean(0, 1, 1, -1, "gaps_junk");
    run_clean(2, 0, 0, 4, "random_arm_in_accum");
    test_early_eop();
    test_sop_mid();
    run_clean(0, 1, 0, -1, "rearm_after_sop");
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
